spi_sim_slave: RTL and testbench
================================

Name: spi_sim_slave

Overview:
Synthesizable SPI slave that answers the team's 16-bit SPI frames (5-bit command, 11-bit data).
- Protocol: CPOL=0; master changes MOSI while SCLK is high and samples MISO on SCLK fall.
- Frame: MSB first. Command bit 4 = R/W (0 write, 1 read); bits 3:0 = register address.
- SCLK, CS_N and MOSI are oversampled in the system clock domain. The block drives a simple external register bus.

Parameters:
CMD_WIDTH, 5, command bits (R/W + address)
ADDR_WIDTH, 4, address bits, CMD_WIDTH-ADDR_WIDTH must be 1
DATA_WIDTH, 11, data bits per frame
WRITE, 0, R/W bit value for write
READ, 1, R/W bit value for read
SYNC_STAGES, 2, synchronizer depth for spi_cs_n/spi_sclk/spi_mosi (≥2)

Ports:
clk  input  1  system clock, ≥8x SCLK frequency
rst  input  1  asynchronous active-high reset
spi_cs_n  input  1  chip select, active low
spi_sclk  input  1  serial clock from master
spi_mosi  input  1  serial data from master
spi_miso  output  1  serial data to master
reg_wr_en  output  1  one-clk write strobe
reg_wr_addr  output  ADDR_WIDTH  write address
reg_wr_data  output  DATA_WIDTH  write data
reg_rd_en  output  1  one-clk read strobe
reg_rd_addr  output  ADDR_WIDTH  read address
reg_rd_data  input  DATA_WIDTH  read data, valid 1 clk after reg_rd_en
busy  output  1  high while a frame is in progress
frame_err  output  1  one-clk pulse on aborted frame

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- Reset values: every output is 0 (spi_miso, strobes, addresses, data, busy, frame_err). FSM is in IDLE, bit counter is 0.
- Input synchronization: each SPI input passes through SYNC_STAGES flops. Rise and fall events come from the last two stages. All SPI edge timing below is therefore delayed by SYNC_STAGES+1 clk.
- FSM: IDLE -> CMD -> DATA -> DONE.
- IDLE: on synchronized CS_N fall, go to CMD. busy=1, bit_cnt=0, shift register cleared.
- CMD: on each SCLK fall, shift MOSI in MSB first and increment bit_cnt.
  - At bit_cnt=CMD_WIDTH, latch cmd and go to DATA.
  - If R/W=READ: pulse reg_rd_en for 1 clk with reg_rd_addr=cmd[3:0]. Capture reg_rd_data into the tx shift register on the following clk.
  - If R/W=WRITE: load the tx register with 0.
- DATA: on each SCLK rise, drive spi_miso from the tx register MSB first. On each SCLK fall, shift MOSI into rx_data. After DATA_WIDTH falls, go to DONE.
- DONE, write frame: pulse reg_wr_en for 1 clk with reg_wr_addr=cmd[3:0] and reg_wr_data=rx_data. Outputs hold until the next write.
- DONE: further SCLK edges are ignored and spi_miso is held at 0 until CS_N rises.
- spi_miso: 0 during CMD, during write frames, and outside frames.
- CS_N rise:
  - in DONE: return to IDLE, busy=0.
  - in CMD or DATA: abort. Pulse frame_err, return to IDLE, no reg_wr_en, spi_miso=0.
  - A read strobe already issued stays issued; read has no side effects by contract.
- CS_N fall while already busy: not possible (busy implies CS_N low).
- SCLK edges while CS_N is high are ignored.
- rst mid-frame: immediate return to reset state, no strobe. The next frame needs a fresh CS_N fall.
- Timing margin: reg_rd_data is consumed within 2 clk of the 5th fall. With clk ≥8x SCLK this precedes the 6th SCLK rise.

Optional Feature:
SPI_SIM_SLAVE_MISO_OE_EN:
- Defined: adds output port spi_miso_oe (1 bit, reset 0). spi_miso_oe=1 only while busy and CS_N is low. spi_miso value is unchanged; the top level builds the tri-state buffer.
- Undefined: the port is absent and spi_miso is always driven.

Decomposition:
- Package spi_sim_pkg holds:
  - CMD/ADDR/DATA width constants and WRITE/READ codes.
  - FSM state typedef: IDLE, CMD, DATA, DONE.
  - Command field slice positions.
- One sub-module: spi_sim_sync_edge. It covers the SYNC_STAGES synchronizer and rise/fall detect, instanced for SCLK and CS_N; MOSI uses the synchronizer only.

Test Plan:
1. Write cmd 5'b0_0011, data 11'h5A5 -> one reg_wr_en pulse, reg_wr_addr=4'h3, reg_wr_data=11'h5A5; spi_miso=0 all frame; no reg_rd_en.
2. Read cmd 5'b1_0111, bench returns reg_rd_data=11'h3C3 -> one reg_rd_en pulse with reg_rd_addr=4'h7; master captures 11'h3C3; no reg_wr_en.
3. Write cmd 5'b0_1111, CS_N raised after 9 SCLK -> frame_err one pulse, no reg_wr_en, busy=0, next full write to addr 4'h1 succeeds.
4. rst asserted after 12 bits of a write -> all outputs 0 immediately, no reg_wr_en; following read of addr 4'h2 returns the bench value correctly.
5. Back-to-back frames: write 11'h7FF to addr 4'hA, then read addr 4'hA with tHI_SCS=400 ns -> both complete; read returns 11'h7FF from the bench model.
6. Write 11'h001 to addr 4'h4 with 20 SCLK pulses -> exactly one reg_wr_en, data 11'h001, extra bits ignored, no frame_err.

Source files
------------

// File: rtl/spi_sim_pkg.sv
// Shared constants and types for the spi_sim_slave register-bus SPI slave.
// A frame is 16 bits, MSB first: {rw, addr[3:0], data[10:0]}.
package spi_sim_pkg;

  localparam int CMD_WIDTH  = 5;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 11;

  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;

  // Field positions inside the 5-bit command word
  localparam int RW_BIT   = CMD_WIDTH - 1;
  localparam int ADDR_MSB = ADDR_WIDTH - 1;

  // Wide enough to count the longer of the two frame phases
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_sim_sync_edge.sv
// Multi-flop synchronizer for one SPI input with rise/fall detection.
// Reset clears the chain to 0. A CS_N held low through reset therefore
// produces no fall, and a frame can only start on a fresh CS_N fall.
module spi_sim_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES:0] chain;

  // Shift the raw input through the synchronizer plus one edge-history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-1:0], d};
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
  assign fall  = ~chain[SYNC_STAGES-1] & chain[SYNC_STAGES];

endmodule

// File: rtl/spi_sim_slave.sv
// SPI slave (CPOL=0) that turns 16-bit frames into register-bus strobes.
// The SPI inputs are oversampled in the clk domain.
// Optional macro SPI_SIM_SLAVE_MISO_OE_EN adds a spi_miso_oe output for an
// external tri-state buffer.
module spi_sim_slave
  import spi_sim_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
`ifdef SPI_SIM_SLAVE_MISO_OE_EN
  output logic                  spi_miso_oe,
`endif
  output logic                  reg_wr_en,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  busy,
  output logic                  frame_err
);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sim_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sim_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sim_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t state, state_n;
  logic start, cmd_done, data_done, abort;

  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [CMD_WIDTH-2:0]  cmd_shift;
  logic [CMD_WIDTH-1:0]  cmd_word;
  logic                  cmd_rw;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [1:0]            rd_pipe;

  // Command bits already received plus the bit arriving on this fall
  assign cmd_word = {cmd_shift, mosi_level};

  assign busy = (state != IDLE);

`ifdef SPI_SIM_SLAVE_MISO_OE_EN
  assign spi_miso_oe = busy & ~cs_level;
`endif

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Frame sequencing; a CS_N rise before DONE aborts the frame
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = CMD;
          start   = 1'b1;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else if (sclk_fall && bit_cnt == CNT_WIDTH'(CMD_WIDTH - 1)) begin
          state_n  = DATA;
          cmd_done = 1'b1;
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else if (sclk_fall && bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
          state_n   = DONE;
          data_done = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift registers, bus strobes and MISO; the read data is captured two
  // clocks after the strobe so the bus has one full clock to respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      cmd_shift   <= '0;
      cmd_rw      <= WRITE;
      cmd_addr    <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rd_pipe     <= '0;
      spi_miso    <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      rd_pipe   <= {rd_pipe[0], 1'b0};

      if (rd_pipe[1]) begin
        tx_shift <= reg_rd_data;
      end

      if (start) begin
        bit_cnt   <= '0;
        cmd_shift <= '0;
        rx_shift  <= '0;
        tx_shift  <= '0;
        rd_pipe   <= '0;
        spi_miso  <= 1'b0;
      end

      if (state == CMD && sclk_fall && !cs_rise) begin
        cmd_shift <= cmd_word[CMD_WIDTH-2:0];
        bit_cnt   <= bit_cnt + CNT_WIDTH'(1);
        if (cmd_done) begin
          bit_cnt  <= '0;
          cmd_rw   <= cmd_word[RW_BIT];
          cmd_addr <= cmd_word[ADDR_MSB:0];
          if (cmd_word[RW_BIT] == READ) begin
            reg_rd_en   <= 1'b1;
            reg_rd_addr <= cmd_word[ADDR_MSB:0];
            rd_pipe     <= 2'b01;
          end else begin
            tx_shift <= '0;
          end
        end
      end

      if (state == DATA && !cs_rise) begin
        if (sclk_rise) begin
          spi_miso <= tx_shift[DATA_WIDTH-1];
          tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
        if (sclk_fall) begin
          rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_level};
          bit_cnt  <= bit_cnt + CNT_WIDTH'(1);
          if (data_done) begin
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
            if (cmd_rw == WRITE) begin
              reg_wr_en   <= 1'b1;
              reg_wr_addr <= cmd_addr;
              reg_wr_data <= {rx_shift, mosi_level};
            end
          end
        end
      end

      if (state == DONE) begin
        spi_miso <= 1'b0;
      end

      if (abort) begin
        frame_err <= 1'b1;
        spi_miso  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sim_slave.sv
// Self-checking bench for spi_sim_slave: a bit-banged SPI master, a
// register-file bus responder and a frame-level model of expected strobes.
module tb_spi_sim_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_addr;
  logic [10:0] reg_wr_data;
  logic        reg_rd_en;
  logic [3:0]  reg_rd_addr;
  logic [10:0] reg_rd_data;
  logic        busy;
  logic        frame_err;
`ifdef SPI_SIM_SLAVE_MISO_OE_EN
  logic        spi_miso_oe;
`endif

  spi_sim_slave dut (
    .clk(clk),
    .rst(rst),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
`ifdef SPI_SIM_SLAVE_MISO_OE_EN
    .spi_miso_oe(spi_miso_oe),
`endif
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [14:0] exp_wr_q[$];
  logic [3:0]  exp_rd_q[$];
  int          exp_err = 0;
  logic [10:0] model_mem[16];
  logic [10:0] bus_mem[16];
  logic        load_mem = 1'b1;
  logic        miso_zero = 1'b1;
  logic [14:0] cmp_wr;
  logic [3:0]  cmp_rd;

  function automatic logic [10:0] init_val(input int i);
    if (i == 7) return 11'h3C3;
    return 11'((i * 291 + 85) & 32'h7FF);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Register file on the far side of the bus: one-clock read latency
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) bus_mem[i] <= init_val(i);
    end else if (reg_wr_en) begin
      bus_mem[reg_wr_addr] <= reg_wr_data;
    end
    if (rst) reg_rd_data <= '0;
    else if (reg_rd_en) reg_rd_data <= bus_mem[reg_rd_addr];
  end

  // Per-cycle compare of bus strobes, frame_err and idle MISO against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          checkOutput("wr_unexpected", 32'(reg_wr_en), 32'd0);
        end else begin
          cmp_wr = exp_wr_q.pop_front();
          checkOutput("wr_addr", 32'(reg_wr_addr), 32'(cmp_wr[14:11]));
          checkOutput("wr_data", 32'(reg_wr_data), 32'(cmp_wr[10:0]));
        end
      end
      if (reg_rd_en) begin
        if (exp_rd_q.size() == 0) begin
          checkOutput("rd_unexpected", 32'(reg_rd_en), 32'd0);
        end else begin
          cmp_rd = exp_rd_q.pop_front();
          checkOutput("rd_addr", 32'(reg_rd_addr), 32'(cmp_rd));
        end
      end
      if (frame_err) begin
        if (exp_err == 0) checkOutput("err_unexpected", 32'(frame_err), 32'd0);
        else exp_err--;
      end
      if (miso_zero) checkOutput("miso_zero", 32'(spi_miso), 32'd0);
    end
  end

  // Bit-bang one frame; nbits SCLK pulses, optional reset after rst_at pulses
  task automatic applyStimulus(input logic [15:0] frame, input int nbits, input int rst_at,
                               output logic [10:0] captured);
    captured = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    checkOutput("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_outputs",
                    32'({spi_miso, reg_wr_en, reg_wr_addr, reg_wr_data,
                         reg_rd_en, reg_rd_addr, busy, frame_err}), 32'd0);
        break;
      end
      if (i == 5 && frame[15]) miso_zero = 1'b0;
      spi_sclk = 1'b1;
      spi_mosi = (i < 16) ? frame[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i >= 5 && i < 16) captured[15-i] = spi_miso;
      spi_sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (rst) begin
      spi_sclk = 1'b0;
      @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end else begin
      spi_cs_n = 1'b1;
    end
  endtask

  // Frame-level model: decide which strobes and errors the frame must cause
  task automatic runFrame(input logic [4:0] cmd, input logic [10:0] data, input int nbits,
                          input int rst_at, input int gap, output logic [10:0] captured);
    logic [10:0] exp_val;
    int          eff;
    logic        full;
    exp_val = model_mem[cmd[3:0]];
    eff  = (rst_at >= 0) ? rst_at : nbits;
    full = (rst_at < 0) && (nbits >= 16);
    if (full) begin
      if (!cmd[4]) begin
        exp_wr_q.push_back({cmd[3:0], data});
        model_mem[cmd[3:0]] = data;
      end else begin
        exp_rd_q.push_back(cmd[3:0]);
      end
    end else begin
      if (rst_at < 0) exp_err++;
      if (cmd[4] && eff >= 5) exp_rd_q.push_back(cmd[3:0]);
    end
    applyStimulus({cmd, data}, nbits, rst_at, captured);
    repeat (gap) @(negedge clk);
    miso_zero = 1'b1;
    checkOutput("wr_missing", 32'(exp_wr_q.size()), 32'd0);
    checkOutput("rd_missing", 32'(exp_rd_q.size()), 32'd0);
    checkOutput("err_missing", 32'(exp_err), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    if (full && cmd[4]) checkOutput("rd_data", 32'(captured), 32'(exp_val));
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_err = 0;
  endtask

  initial begin
    logic [10:0] cap;
    logic [4:0]  rcmd;
    logic [10:0] rdata;
    int          sel, nb;
    for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({spi_miso, reg_wr_en, reg_wr_addr, reg_wr_data,
                     reg_rd_en, reg_rd_addr, busy, frame_err}), 32'd0);
`ifdef SPI_SIM_SLAVE_MISO_OE_EN
    checkOutput("reset_miso_oe", 32'(spi_miso_oe), 32'd0);
`endif
    load_mem = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] write addr 3");
    runFrame(5'b0_0011, 11'h5A5, 16, -1, 16, cap);
    checkOutput("t1_wr_addr", 32'(reg_wr_addr), 32'h3);
    checkOutput("t1_wr_data", 32'(reg_wr_data), 32'h5A5);

    $display("[TB] read addr 7");
    runFrame(5'b1_0111, 11'h000, 16, -1, 16, cap);
    checkOutput("t2_rd_lit", 32'(cap), 32'h3C3);

    $display("[TB] aborted write then write addr 1");
    runFrame(5'b0_1111, 11'h123, 9, -1, 16, cap);
    runFrame(5'b0_0001, 11'h456, 16, -1, 16, cap);
    checkOutput("t3_wr_data", 32'(reg_wr_data), 32'h456);

    $display("[TB] reset mid-frame then read addr 2");
    runFrame(5'b0_0010, 11'h0F0, 16, 12, 16, cap);
    runFrame(5'b1_0010, 11'h000, 16, -1, 16, cap);

    $display("[TB] back-to-back write/read addr A");
    runFrame(5'b0_1010, 11'h7FF, 16, -1, 40, cap);
    runFrame(5'b1_1010, 11'h000, 16, -1, 40, cap);
    checkOutput("t5_rd_lit", 32'(cap), 32'h7FF);

    $display("[TB] write with 20 pulses");
    runFrame(5'b0_0100, 11'h001, 20, -1, 16, cap);
    checkOutput("t6_wr_data", 32'(reg_wr_data), 32'h001);

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      rcmd  = 5'($urandom_range(0, 31));
      rdata = 11'($urandom_range(0, 2047));
      sel   = $urandom_range(0, 9);
      nb    = (sel < 2) ? $urandom_range(1, 15) : ((sel == 2) ? $urandom_range(17, 20) : 16);
      runFrame(rcmd, rdata, nb, -1, $urandom_range(16, 40), cap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit guard in case the stimulus never completes
  initial begin
    #3ms;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
